// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds FSM state encoding, port id type and memory geometry defaults.
package dmem_pkg;

    localparam int MEM_BYTES_DEFAULT = 8192;
    localparam int WORD_OFF_W        = 3;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    typedef logic port_id_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant picker, one-hot output.
// Latency: combinational. Backpressure: none, pure function of req and last.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic [1:0] req,
    input  port_id_t   last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // Contention: the port that did not win last time goes first.
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin 2-port arbiter in front of the sync-read data memory; DMEM_ALIGN_CHECK_EN flags unaligned addresses.
// Latency: write done in grant cycle; read data 1 cycle after grant. Backpressure: requests held until gnt, no grant in RESP.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              rerr,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writeData,
    output logic              mem_MemWrite,
    output logic              mem_MemRead,
    input  logic [DATA_W-1:0] mem_readData
);

    localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);

    state_t            state;
    port_id_t          last_gnt;
    port_id_t          lat_id;
    logic              lat_err;

    logic              issue_en;
    logic              resp_act;
    logic [1:0]        arb_req;
    logic [1:0]        gnt;
    logic              any_gnt;
    port_id_t          win_id;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              win_err;

    assign issue_en = (state == IDLE) && !reset;
    assign resp_act = (state == RESP) && !reset;
    assign arb_req  = {p1_req, p0_req} & {2{issue_en}};

    rr_arb2 u_arb (
        .req  (arb_req),
        .last (last_gnt),
        .gnt  (gnt)
    );

    always_comb begin
        any_gnt   = |gnt;
        win_id    = gnt[1];
        win_we    = win_id ? p1_we    : p0_we;
        win_addr  = win_id ? p1_addr  : p0_addr;
        win_wdata = win_id ? p1_wdata : p0_wdata;
        win_err   = (win_addr >= MEM_LIMIT);
`ifdef DMEM_ALIGN_CHECK_EN
        if (win_addr[WORD_OFF_W-1:0] != '0) begin
            win_err = 1'b1;
        end
`endif
    end

    assign p0_gnt        = gnt[0];
    assign p1_gnt        = gnt[1];
    assign mem_address   = any_gnt ? win_addr  : '0;
    assign mem_writeData = any_gnt ? win_wdata : '0;
    // Errored accesses are granted but never reach the memory.
    assign mem_MemWrite  = any_gnt &&  win_we && !win_err;
    assign mem_MemRead   = any_gnt && !win_we && !win_err;

    assign p0_rvalid = resp_act && !lat_id;
    assign p1_rvalid = resp_act &&  lat_id;
    assign rdata     = (resp_act && !lat_err) ? mem_readData : '0;
    assign rerr      = resp_act && lat_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            lat_id   <= 1'b0;
            lat_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_gnt) begin
                        last_gnt <= win_id;
                        if (!win_we) begin
                            lat_id  <= win_id;
                            lat_err <= win_err;
                            state   <= RESP;
                        end
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised and directed bench for dmem_arbiter against a transaction-level reference model.
// Includes a 1024x64 sync-read memory to close the loop on mem_* strobes.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        r_req   [2];
    logic        r_we    [2];
    logic [63:0] r_addr  [2];
    logic [63:0] r_wdata [2];

    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, rerr;
    logic [63:0] rdata, mem_address, mem_writeData;
    logic        mem_MemWrite, mem_MemRead;
    logic [63:0] mem_readData = '0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .p0_req        (r_req[0]),
        .p0_we         (r_we[0]),
        .p0_addr       (r_addr[0]),
        .p0_wdata      (r_wdata[0]),
        .p0_gnt        (p0_gnt),
        .p0_rvalid     (p0_rvalid),
        .p1_req        (r_req[1]),
        .p1_we         (r_we[1]),
        .p1_addr       (r_addr[1]),
        .p1_wdata      (r_wdata[1]),
        .p1_gnt        (p1_gnt),
        .p1_rvalid     (p1_rvalid),
        .rdata         (rdata),
        .rerr          (rerr),
        .mem_address   (mem_address),
        .mem_writeData (mem_writeData),
        .mem_MemWrite  (mem_MemWrite),
        .mem_MemRead   (mem_MemRead),
        .mem_readData  (mem_readData)
    );

    // Memory behind the arbiter: word select from address[12:3], one-cycle read.
    logic [63:0] env_mem [0:1023];
    always @(posedge clk) begin
        if (mem_MemWrite) env_mem[mem_address[12:3]] <= mem_writeData;
        if (mem_MemRead)  mem_readData <= env_mem[mem_address[12:3]];
    end

    typedef struct {
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } txn_t;

    txn_t q0[$];
    txn_t q1[$];

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state: pending response and fairness pointer.
    bit          m_pend = 0;
    int          m_port = 0;
    bit          m_err = 0;
    logic [63:0] m_data = '0;
    int          m_last = 1;
    logic [63:0] ref_mem [int];
    logic [1:0]  gnt_w = 2'b00;
    int          load_pct = 100;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit addr_err(input logic [63:0] a);
        bit e;
        e = (a >= 64'd8192);
`ifdef DMEM_ALIGN_CHECK_EN
        if (a[2:0] != 3'd0) e = 1'b1;
`endif
        return e;
    endfunction

    task automatic model_cycle();
        logic [1:0]  eg;
        logic [1:0]  erv;
        logic [63:0] e_rdata, e_addr, e_wd;
        bit          e_rerr, e_wr, e_rd;
        int          w;
        eg = 2'b00; erv = 2'b00; e_rdata = '0; e_addr = '0; e_wd = '0;
        e_rerr = 0; e_wr = 0; e_rd = 0; w = -1;
        gnt_w = 2'b00;
        if (reset) begin
            m_pend = 0;
            m_last = 1;
        end else if (m_pend) begin
            erv[m_port] = 1'b1;
            e_rerr  = m_err;
            e_rdata = m_err ? 64'd0 : m_data;
            m_pend  = 0;
        end else begin
            if (r_req[0] && r_req[1]) w = (m_last == 0) ? 1 : 0;
            else if (r_req[0])        w = 0;
            else if (r_req[1])        w = 1;
            if (w >= 0) begin
                bit err;
                int idx;
                err = addr_err(r_addr[w]);
                idx = int'(r_addr[w] >> 3);
                eg[w] = 1'b1;
                gnt_w[w] = 1'b1;
                e_addr = r_addr[w];
                e_wd = r_wdata[w];
                m_last = w;
                if (r_we[w]) begin
                    e_wr = !err;
                    if (!err) ref_mem[idx] = r_wdata[w];
                end else begin
                    e_rd = !err;
                    m_pend = 1;
                    m_port = w;
                    m_err = err;
                    m_data = ref_mem.exists(idx) ? ref_mem[idx] : 64'd0;
                end
            end
        end
        chk("p0_gnt", p0_gnt, eg[0]);
        chk("p1_gnt", p1_gnt, eg[1]);
        chk("p0_rvalid", p0_rvalid, erv[0]);
        chk("p1_rvalid", p1_rvalid, erv[1]);
        chk("rdata", rdata, e_rdata);
        chk("rerr", rerr, e_rerr);
        chk("mem_MemWrite", mem_MemWrite, e_wr);
        chk("mem_MemRead", mem_MemRead, e_rd);
        chk("mem_address", mem_address, e_addr);
        chk("mem_writeData", mem_writeData, e_wd);
    endtask

    task automatic load_port(input int i);
        txn_t t;
        if (r_req[i]) return;
        if (i == 0 && q0.size() == 0) return;
        if (i == 1 && q1.size() == 0) return;
        if ($urandom_range(99) >= load_pct) return;
        t = (i == 0) ? q0.pop_front() : q1.pop_front();
        r_req[i] = 1'b1;
        r_we[i] = t.we;
        r_addr[i] = t.addr;
        r_wdata[i] = t.wdata;
    endtask

    task automatic post_edge();
        for (int i = 0; i < 2; i++) begin
            if (gnt_w[i]) r_req[i] = 1'b0;
        end
        load_port(0);
        load_port(1);
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
        post_edge();
    endtask

    task automatic drain();
        int budget;
        budget = 3000;
        while ((q0.size() != 0 || q1.size() != 0 || r_req[0] || r_req[1] || m_pend) && budget > 0) begin
            step();
            budget--;
        end
        chk("drain_left", 64'(q0.size() + q1.size() + int'(r_req[0]) + int'(r_req[1])), 64'd0);
    endtask

    task automatic push(input int port, input bit we, input logic [63:0] addr, input logic [63:0] wdata);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wdata;
        if (port == 0) q0.push_back(t);
        else           q1.push_back(t);
    endtask

    function automatic logic [63:0] rand_addr();
        int r;
        r = $urandom_range(9);
        if (r < 7)       return 64'($urandom_range(31)) << 3;
        else if (r == 7) return ($urandom_range(1) == 0) ? (64'h2000 + (64'($urandom_range(31)) << 3))
                                                          : {$urandom(), $urandom()} | 64'h8000_0000_0000_0000;
        else if (r == 8) return (64'($urandom_range(31)) << 3) + 64'($urandom_range(7, 1));
        else             return 64'h1FF8;
    endfunction

    initial begin
        int b;
        for (int i = 0; i < 1024; i++) env_mem[i] = '0;
        for (int i = 0; i < 2; i++) begin
            r_req[i] = 0; r_we[i] = 0; r_addr[i] = '0; r_wdata[i] = '0;
        end

        // Reset state.
        repeat (3) step();
        reset = 1'b0;

        // Write then read back on port 0.
        push(0, 1, 64'h10, 64'hDEADBEEF);
        push(0, 0, 64'h10, 64'h0);
        drain();

        // Both ports reading continuously.
        for (int i = 0; i < 8; i++) begin
            push(0, 0, 64'(i) << 3, 64'h0);
            push(1, 0, 64'h10, 64'h0);
        end
        drain();

        // Out-of-range read and write on port 1.
        push(1, 0, 64'h2000, 64'h0);
        push(1, 1, 64'h2000, 64'h1234);
        push(1, 0, 64'h1FF8, 64'h0);
        drain();

        // Back-to-back writes from both ports, then readback.
        push(0, 1, 64'h0,  64'hA0A0_0000_0000_0001);
        push(1, 1, 64'h8,  64'hB0B0_0000_0000_0002);
        push(0, 1, 64'h10, 64'hC0C0_0000_0000_0003);
        drain();
        push(0, 0, 64'h0, 64'h0);
        push(0, 0, 64'h8, 64'h0);
        push(1, 0, 64'h10, 64'h0);
        drain();

        // Unaligned read of word 0.
        push(0, 1, 64'h0, 64'h5555_AAAA_1234_5678);
        push(0, 0, 64'h4, 64'h0);
        drain();

        // Reset while a read response is due; pending response must vanish.
        push(0, 0, 64'h10, 64'h0);
        push(1, 0, 64'h8, 64'h0);
        b = 50;
        do begin
            step();
            b--;
        end while (!m_pend && b > 0);
        chk("rst_resp_reached", 64'(m_pend), 64'd1);
        push(0, 0, 64'h0, 64'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        drain();

        // Randomised traffic with idle gaps.
        load_pct = 60;
        for (int i = 0; i < 200; i++) begin
            push(0, $urandom_range(1) == 1, rand_addr(), {$urandom(), $urandom()});
            push(1, $urandom_range(1) == 1, rand_addr(), {$urandom(), $urandom()});
        end
        drain();
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester round-robin arbiter and sequencer in front of the 64-bit synchronous-read data memory (1024 x 64b, 8 KB).
- Port 0 serves the pipeline load/store unit; port 1 serves the debug/loader port.
- Issues one access per grant and drives the memory's address/writeData/MemWrite/MemRead strobes.
- Tracks the 1-cycle read latency and returns read data with a per-port valid pulse.
- Flags out-of-range accesses instead of forwarding them.

Parameters:
ADDR_W, 64, requester/memory address width in bits.
DATA_W, 64, data width in bits.
MEM_BYTES, 8192, size of the valid byte range; addresses >= MEM_BYTES are errors.

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
p0_req  in  1  port 0 request, held until granted
p0_we  in  1  port 0 write (1) / read (0)
p0_addr  in  ADDR_W  port 0 byte address
p0_wdata  in  DATA_W  port 0 write data
p0_gnt  out  1  port 0 request accepted this cycle
p0_rvalid  out  1  port 0 read response valid
p1_req/p1_we/p1_addr/p1_wdata  in  1/1/ADDR_W/DATA_W  port 1, same meaning as port 0
p1_gnt/p1_rvalid  out  1/1  port 1, same meaning as port 0
rdata  out  DATA_W  read data, shared by both ports, qualified by pX_rvalid
rerr  out  1  response is an error, qualified by pX_rvalid
mem_address  out  ADDR_W  to memory address
mem_writeData  out  DATA_W  to memory writeData
mem_MemWrite  out  1  to memory MemWrite
mem_MemRead  out  1  to memory MemRead
mem_readData  in  DATA_W  from memory readData, valid the cycle after MemRead

Behaviour:
- FSM with 2 states: IDLE and RESP.
- IDLE:
  - If any request is present, grant exactly one requester.
  - Winner is chosen round-robin from a 1-bit last_gnt register; port 0 wins on a tie after reset.
  - pX_gnt is combinational in the issue cycle. mem_* are driven from the winner's fields in the same cycle.
  - Write: mem_MemWrite=1 and the access completes that cycle. Stay in IDLE; no response is produced.
  - Read: mem_MemRead=1. Latch the winner id and the error flag, then go to RESP.
- RESP (exactly 1 cycle):
  - pX_rvalid=1 for the latched port only.
  - rdata=mem_readData (combinational pass-through) and rerr=latched error flag.
  - No grant is given in RESP. Return to IDLE.
  - Read throughput is therefore 1 per 2 cycles; write throughput is 1 per cycle.
- Range check: addr >= MEM_BYTES (full ADDR_W compare) is still granted.
  - mem_MemWrite/mem_MemRead are suppressed for that access.
  - A read still produces RESP with rerr=1 and rdata=0; an out-of-range write is dropped silently.
- last_gnt updates on every grant, so a continuously requesting port cannot starve the other.
- Idle outputs:
  - When no grant is given, mem_MemWrite=0 and mem_MemRead=0.
  - mem_address/mem_writeData=0 in that case.
  - All gnt/rvalid outputs=0; rdata=0 and rerr=0 outside RESP.
- Reset:
  - FSM goes to IDLE, last_gnt=1 (so port 0 wins first), and the latched id/error clear.
  - All outputs go low or zero.
  - A reset asserted during RESP drops the pending response; no rvalid is produced after reset.
- Requesters must hold req/we/addr/wdata stable until gnt. The arbiter does not buffer requests.

Optional Feature:
DMEM_ALIGN_CHECK_EN
- Defined: addr[2:0] != 0 is also an error, handled exactly like an out-of-range access (strobes suppressed, read returns rerr=1, rdata=0).
- Undefined: addr[2:0] is ignored, and the memory selects the word using address[12:3].

Decomposition:
- Shared package dmem_pkg holds:
  - localparam MEM_BYTES_DEFAULT = 8192 and the word-offset width (3).
  - An enum for the FSM states {IDLE, RESP}.
  - The port-id typedef (1 bit).
- One natural sub-module: rr_arb2, a 2-way round-robin grant picker (inputs req[1:0] and last; output one-hot gnt).

Test Plan:
- Reset, then p0 writes addr 0x10 with 0xDEADBEEF; p0 then reads 0x10 -> p0_gnt in the issue cycle; on the read, p0_rvalid 1 cycle later with rdata=0xDEADBEEF and rerr=0.
- p0 and p1 both reading continuously -> grants alternate p0,p1,p0,... with an issue/response gap of 1 cycle; rvalid goes only to the matching port.
- p1 reads 0x2000 -> mem_MemRead stays 0; p1_rvalid with rerr=1 and rdata=0. p1 writes 0x2000 -> mem_MemWrite stays 0.
- Back-to-back writes p0@0x0, p1@0x8, p0@0x10 -> 3 consecutive mem_MemWrite cycles; a later readback returns each value.
- Assert reset during RESP -> p0_rvalid/p1_rvalid stay 0. The next simultaneous request is granted to p0.
- With DMEM_ALIGN_CHECK_EN defined, p0 reads 0x4 -> rerr=1, rdata=0, no MemRead. Without the macro, the same read returns the word at 0x0.
